// File: rtl/idu_pkg.sv
// Shared types and constants for the IDU receive path.
package idu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } rx_state_t;

  localparam logic [31:0] INST_NOP        = 32'h0000_0013;
  localparam int          STALL_CNT_WIDTH = 16;
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/idu_rx_buf.sv
// Two-entry receive buffer between the IFU stage register and IDU decode.
// Upstream ready and downstream valid are registered so no input reaches an output combinationally.
module idu_rx_buf
  import idu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RST_PC     = 32'h8000_0000
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst_n,
  input  logic                       i_ifu_valid,
  output logic                       o_ifu_ready,
  input  logic [ADDR_WIDTH-1:0]      i_ifu_pc,
  input  logic [ADDR_WIDTH-1:0]      i_ifu_pc_next,
  input  logic [INST_WIDTH-1:0]      i_ifu_inst,
  output logic                       o_idu_valid,
  input  logic                       i_idu_ready,
  output logic [ADDR_WIDTH-1:0]      o_idu_pc,
  output logic [ADDR_WIDTH-1:0]      o_idu_pc_next,
  output logic [INST_WIDTH-1:0]      o_idu_inst,
  input  logic                       i_flush,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

  rx_state_t state_q;
  rx_state_t state_d;

  logic ready_q;
  logic valid_q;

  logic push;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  logic [ADDR_WIDTH-1:0]      main_pc;
  logic [ADDR_WIDTH-1:0]      main_pc_next;
  logic [INST_WIDTH-1:0]      main_inst;
  logic [ADDR_WIDTH-1:0]      skid_pc;
  logic [ADDR_WIDTH-1:0]      skid_pc_next;
  logic [INST_WIDTH-1:0]      skid_inst;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  assign push = i_ifu_valid & ready_q;
  assign pop  = valid_q & i_idu_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // A redirect drops everything; data registers simply keep stale contents.
    if (i_flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      main_pc      <= RST_PC;
      main_pc_next <= RST_PC;
      main_inst    <= INST_WIDTH'(INST_NOP);
    end else if (load_main_in) begin
      main_pc      <= i_ifu_pc;
      main_pc_next <= i_ifu_pc_next;
      main_inst    <= i_ifu_inst;
    end else if (load_main_skid) begin
      main_pc      <= skid_pc;
      main_pc_next <= skid_pc_next;
      main_inst    <= skid_inst;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      skid_pc      <= RST_PC;
      skid_pc_next <= RST_PC;
      skid_inst    <= INST_WIDTH'(INST_NOP);
    end else if (load_skid) begin
      skid_pc      <= i_ifu_pc;
      skid_pc_next <= i_ifu_pc_next;
      skid_inst    <= i_ifu_inst;
    end
  end

  // Counts decoder backpressure for the perf CSRs; flush deliberately ignored.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      stall_cnt <= '0;
    end else if (valid_q && !i_idu_ready && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_ifu_ready   = ready_q;
  assign o_idu_valid   = valid_q;
  assign o_idu_pc      = main_pc;
  assign o_idu_pc_next = main_pc_next;
  assign o_idu_inst    = main_inst;
  assign o_stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_idu_rx_buf.sv
// Scoreboard bench for idu_rx_buf: a queue model of the two-entry buffer is
// updated as stimulus is driven and compared against the DUT every cycle.
module tb_idu_rx_buf;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_pc_next;
  logic [31:0] ifu_inst;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] idu_pc;
  logic [31:0] idu_pc_next;
  logic [31:0] idu_inst;
  logic        flush;
  logic [15:0] stall_cnt;

  int          errors = 0;
  int          checks = 0;
  pkt_t        model_q[$];
  logic [15:0] model_cnt;
  bit          pending;
  logic [31:0] seq;
  logic        cur_v;
  logic [31:0] cur_pc;
  logic [31:0] cur_pcn;
  logic [31:0] cur_inst;

  always #5 clk = ~clk;

  idu_rx_buf #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RST_PC    (RST_PC)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_ifu_valid  (ifu_valid),
    .o_ifu_ready  (ifu_ready),
    .i_ifu_pc     (ifu_pc),
    .i_ifu_pc_next(ifu_pc_next),
    .i_ifu_inst   (ifu_inst),
    .o_idu_valid  (idu_valid),
    .i_idu_ready  (idu_ready),
    .o_idu_pc     (idu_pc),
    .o_idu_pc_next(idu_pc_next),
    .o_idu_inst   (idu_inst),
    .i_flush      (flush),
    .o_stall_cnt  (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs (called at posedge+1), checks the DUT against the
  // model, updates the model for the coming edge and advances to the next cycle.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] pcn,
                               input logic [31:0] inst, input logic rdy, input logic fl);
    logic        pre_ready;
    logic        pre_valid;
    logic [31:0] pre_pc;
    logic        do_push;
    logic        do_pop;
    pkt_t        p;
    pre_ready   = ifu_ready;
    pre_valid   = idu_valid;
    pre_pc      = idu_pc;
    ifu_valid   = v;
    ifu_pc      = pc;
    ifu_pc_next = pcn;
    ifu_inst    = inst;
    idu_ready   = rdy;
    flush       = fl;
    #1;
    checkOutput("comb_ready", 32'(ifu_ready), 32'(pre_ready));
    checkOutput("comb_valid", 32'(idu_valid), 32'(pre_valid));
    checkOutput("comb_pc", idu_pc, pre_pc);
    checkOutput("ifu_ready", 32'(ifu_ready), 32'(model_q.size() < 2));
    checkOutput("idu_valid", 32'(idu_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("head_pc", idu_pc, model_q[0].pc);
      checkOutput("head_pc_next", idu_pc_next, model_q[0].pc_next);
      checkOutput("head_inst", idu_inst, model_q[0].inst);
    end
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(model_cnt));

    do_push = v && (model_q.size() < 2);
    do_pop  = (model_q.size() != 0) && rdy;
    if ((model_q.size() != 0) && !rdy && (model_cnt != 16'hFFFF)) model_cnt++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        p.pc      = pc;
        p.pc_next = pcn;
        p.inst    = inst;
        model_q.push_back(p);
      end
    end
    pending = v && !do_push && !fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, 32'(idu_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ifu_ready), 32'd1);
    checkOutput({tag, "_pc"}, idu_pc, RST_PC);
    checkOutput({tag, "_pc_next"}, idu_pc_next, RST_PC);
    checkOutput({tag, "_inst"}, idu_inst, NOP);
    checkOutput({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    ifu_valid   = 1'b0;
    ifu_pc      = '0;
    ifu_pc_next = '0;
    ifu_inst    = '0;
    idu_ready   = 1'b0;
    flush       = 1'b0;
    model_cnt   = '0;
    pending     = 1'b0;
    seq         = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkReset("rst_init");
    rst_n = 1'b1;

    // Back-to-back stream with the decoder always ready.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, RST_PC + 32'(4 * i), RST_PC + 32'(4 * i + 4), 32'h0010_0093 + 32'(i << 20), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Backpressure: A, B absorbed, C held upstream until the buffer drains.
    applyStimulus(1'b1, 32'h0000_1000, 32'h0000_1004, 32'hAAAA_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_1004, 32'h0000_1008, 32'hBBBB_0002, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 32'h0000_1008, 32'h0000_100C, 32'hCCCC_0003, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 32'h0000_1008, 32'h0000_100C, 32'hCCCC_0003, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("bp_stall_total", 32'(stall_cnt), 32'd4);

    // Flush while full with a packet offered; then D must reach the head.
    applyStimulus(1'b1, 32'h0000_2000, 32'h0000_2004, 32'hEEEE_0004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2004, 32'h0000_2008, 32'hFFFF_0005, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2008, 32'h0000_200C, 32'h7777_0006, 1'b0, 1'b1);
    checkOutput("flush_valid", 32'(idu_valid), 32'd0);
    checkOutput("flush_ready", 32'(ifu_ready), 32'd1);
    applyStimulus(1'b1, 32'h0000_3000, 32'h0000_3004, 32'hDDDD_0007, 1'b1, 1'b0);
    checkOutput("post_flush_pc", idu_pc, 32'h0000_3000);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Saturation: one entry stuck at the head for 70000 cycles.
    applyStimulus(1'b1, 32'h0000_4000, 32'h0000_4004, 32'h1234_5678, 1'b0, 1'b0);
    ifu_valid = 1'b0;
    idu_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    model_cnt = 16'hFFFF;
    checkOutput("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset asserted between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("rst_async");
    model_q.delete();
    model_cnt = '0;
    pending   = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic; an unaccepted packet is held stable unless flushed.
    cur_v = 1'b0;
    cur_pc = '0;
    cur_pcn = '0;
    cur_inst = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pending) begin
        cur_v    = ($urandom_range(0, 3) != 0);
        cur_pc   = RST_PC + (seq << 2);
        cur_pcn  = cur_pc + 32'd4;
        cur_inst = $urandom;
        seq++;
      end
      applyStimulus(cur_v, cur_pc, cur_pcn, cur_inst,
                    logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idu_rx_buf.md
# idu_rx_buf

IDU-side receive end of the IFU→IDU handshake: accepts fetched instruction packets (pc, pc_next, inst) under valid/ready, buffers up to two entries so upstream ready is a pure register output, and presents them in order to the decoder. It sits between the IFU stage register and the IDU decode logic and supports a same-cycle flush on branch redirect. A saturating stall counter feeds the performance CSRs.

## Interface
- ADDR_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction width
- RST_PC, 32'h8000_0000, reset value of the pc outputs and skid pc registers
- i_sys_clk  in  1  clock, rising edge
- i_sys_rst_n  in  1  reset; asynchronous and active-low
- i_ifu_valid  in  1  upstream packet valid
- o_ifu_ready  out  1  buffer can accept a packet
- i_ifu_pc  in  ADDR_WIDTH  packet pc
- i_ifu_pc_next  in  ADDR_WIDTH  packet predicted next pc
- i_ifu_inst  in  INST_WIDTH  packet instruction
- o_idu_valid  out  1  head entry valid
- i_idu_ready  in  1  decoder consumes head
- o_idu_pc  out  ADDR_WIDTH  head pc
- o_idu_pc_next  out  ADDR_WIDTH  head pc_next
- o_idu_inst  out  INST_WIDTH  head instruction
- i_flush  in  1  redirect; discard all buffered and incoming packets
- o_stall_cnt  out  16  saturating count of head-valid-but-not-ready cycles

## Operation
- push = i_ifu_valid & o_ifu_ready; pop = o_idu_valid & i_idu_ready.
- Storage: head register (main) and skid register; FIFO order, head always older.
- States: EMPTY, ONE, FULL (state register, 2 bits).
- EMPTY: push → ONE, main ← input.
- ONE: push & pop → ONE, main ← input; push & !pop → FULL, skid ← input; pop & !push → EMPTY; neither → ONE.
- FULL: pop → ONE, main ← skid; no pop → FULL. push cannot occur (ready low).
- o_ifu_ready = (state != FULL); o_idu_valid = (state != EMPTY); o_idu_* driven directly from main registers.
- i_flush has top priority: next state EMPTY regardless of push/pop; incoming packet discarded; data registers keep their values (not cleared); pop in flush cycle carries no meaning to this block.
- i_ifu_valid with o_ifu_ready low: ignored; upstream holds packet stable.
- o_stall_cnt: +1 each cycle with o_idu_valid & !i_idu_ready, saturates at 16'hFFFF, not affected by flush, cleared only by reset.
- Reset (async assert): state EMPTY, o_ifu_ready 1, o_idu_valid 0, o_idu_pc/o_idu_pc_next RST_PC, o_idu_inst 32'h0000_0013 (NOP), skid regs same values, o_stall_cnt 0.

## Timing
- Latency: packet pushed in cycle N appears at o_idu_* with o_idu_valid in cycle N+1 (EMPTY or ONE-with-pop case).
- Throughput: one packet/cycle sustained when i_idu_ready held high.
- o_ifu_ready and o_idu_valid are flop outputs decoded from state only; no combinational path from any input to any output.
- Downstream backpressure: ready drops one cycle after the second unconsumed push; exactly two packets absorbed after ready deassert-to-stall, none lost.
- FULL → pop: ready high next cycle; skid packet at head next cycle.
- Flush cycle N: o_idu_valid 0 and o_ifu_ready 1 in N+1; first post-flush push at N+1 visible at N+2.
- Reset deassertion mid-operation: first edge after release behaves as from EMPTY.

## Structure
- Shared package idu_pkg: typedef enum rx_state_t {EMPTY, ONE, FULL}; constant INST_NOP = 32'h0000_0013; constant STALL_CNT_MAX.
- Single module; no sub-module (two entry registers are too small to justify one).

## Test plan
- Reset: hold i_sys_rst_n low mid-clock → outputs immediately o_idu_valid 0, o_ifu_ready 1, o_idu_pc 32'h8000_0000, o_idu_inst 32'h0000_0013, o_stall_cnt 0.
- Streaming: push pc 0x8000_0000..0x8000_000C back-to-back, i_idu_ready 1 → each appears one cycle later in order, ready never drops.
- Backpressure: i_idu_ready 0, push A,B,C continuously → state FULL, ready 0, C held; release ready → A,B,C out in order, no loss/dup, o_stall_cnt equals stall cycles.
- Flush while FULL with simultaneous push → next cycle valid 0, ready 1, pushed packet never emerges; push D after → D at head.
- Saturation: force 70000 stall cycles → o_stall_cnt stops at 0xFFFF.
- Random valid/ready/flush 10k cycles against scoreboard FIFO model → exact order match, no output toggles combinationally on inputs.
